// File: rtl/regfile_pkg.sv
// Shared register-file types and default geometry.
// Also used by the decode-stage hazard unit.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register,
// set at issue, cleared at writeback, looked up per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_all_i,
  input  logic                 set_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic                 clr_i,
  input  logic [AW-1:0]        clr_addr_i,
  input  logic [NUM_RD*AW-1:0] lk_addr_i,
  output logic [NUM_RD-1:0]    lk_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clear first so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    if (clr_all_i) busy_d = '0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lk
    logic [AW-1:0] a;
    logic          fwd;
    assign a   = lk_addr_i[k*AW +: AW];
    // A same-cycle writeback is forwarded, so it does not stall.
    assign fwd = (BYPASS != 0) && clr_i && (clr_addr_i == a);
    assign lk_busy_o[k] = busy_q[a] & ~fwd;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read-port integer register file with sequenced clear,
// optional zero register, write bypass and pending-write scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = RF_WIDTH,
  parameter int  DEPTH    = RF_DEPTH,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    ready,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    busy_set,
  input  logic [AW-1:0]           busy_addr
);

  rf_state_e  state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          in_clr;
  logic          wr_ok;
  logic          wr_fwd;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [NUM_RD-1:0] sb_busy;

  assign ready  = (state_q == READY);
  assign in_clr = ~ready;

  // Writes are only honoured in READY and never alongside a clear request.
  assign wr_ok  = ready & ~clear_req & wr_en;
  assign wr_fwd = wr_ok & ~((ZERO_REG != 0) && (wr_addr == '0));

  // Single array write port shared by the sweep and writeback.
  assign mem_we = in_clr | wr_fwd;
  assign mem_wa = in_clr ? clr_cnt_q : wr_addr;
  assign mem_wd = in_clr ? '0 : wr_data;

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Sequencer state and sweep pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    assign a = rd_addr[k*AW +: AW];
    // Read mux with bypass, zero-register and clear overrides.
    always_comb begin
      v = mem_q[a];
      if ((BYPASS != 0) && wr_fwd && (wr_addr == a)) v = wr_data;
      if ((ZERO_REG != 0) && (a == '0)) v = '0;
      if (in_clr) v = '0;
    end
    assign rd_data[k*WIDTH +: WIDTH] = v;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .clr_all_i  (in_clr | clear_req),
    .set_i      (ready & ~clear_req & busy_set),
    .set_addr_i (busy_addr),
    .clr_i      (wr_ok),
    .clr_addr_i (wr_addr),
    .lk_addr_i  (rd_addr),
    .lk_busy_o  (sb_busy)
  );

  assign rd_busy = ready ? sb_busy : '0;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two register files (bypass+zero, and neither)
// driven identically and checked against an array-level model.
module tb_regfile_multiport;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;
  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_req = 1'b0;
  logic wr_en = 1'b0;
  logic busy_set = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [A-1:0] busy_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [N*A-1:0] rd_addr = '0;

  logic rdy_a, rdy_b;
  logic [N*W-1:0] rdd_a, rdd_b;
  logic [N-1:0] rbz_a, rbz_b;

  always #5 clk = ~clk;

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(N), .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(rdy_a),
    .rd_addr(rd_addr), .rd_data(rdd_a), .rd_busy(rbz_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(N), .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(rdy_b),
    .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rbz_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  typedef struct packed {
    logic [1:0]                rdy;
    logic [1:0][1:0][W-1:0]    d;
    logic [1:0][1:0]           b;
  } exp_t;

  exp_t q[$];

  // Model: index 0 = zero-reg + bypass, index 1 = plain.
  logic [W-1:0] mm [2][D];
  bit           mb [2][D];
  int           sweep = D;

  int npass = 0;
  int ntot  = 0;

  function automatic bit zr(int i);
    return (i == 0);
  endfunction

  function automatic bit bp(int i);
    return (i == 0);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    for (int i = 0; i < 2; i++) begin
      e.rdy[i] = (sweep == 0);
      if (sweep == 0) begin
        for (int k = 0; k < N; k++) begin
          logic [A-1:0] a;
          logic [W-1:0] v;
          bit we, bz;
          a  = rd_addr[k*A +: A];
          we = wr_en && !clear_req;
          v  = mm[i][a];
          if (bp(i) && we && wr_addr == a && !(zr(i) && wr_addr == 0))
            v = wr_data;
          if (zr(i) && a == 0) v = '0;
          bz = mb[i][a];
          if (bp(i) && we && wr_addr == a) bz = 1'b0;
          e.d[i][k] = v;
          e.b[i][k] = bz;
        end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    sweep = D;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < D; j++) mb[i][j] = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) return;
    if (sweep > 0) begin
      for (int i = 0; i < 2; i++) mm[i][D-sweep] = '0;
      sweep--;
    end else if (clear_req) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && !(zr(i) && wr_addr == 0)) mm[i][wr_addr] = wr_data;
        if (wr_en) mb[i][wr_addr] = 1'b0;
        if (busy_set && !(zr(i) && busy_addr == 0)) mb[i][busy_addr] = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit we,
                     input logic [A-1:0] wa, input logic [W-1:0] wd,
                     input bit bs, input logic [A-1:0] ba,
                     input logic [A-1:0] r0, input logic [A-1:0] r1);
    @(posedge clk);
    #1;
    model_edge();
    reset     = r;
    clear_req = c;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    busy_set  = bs;
    busy_addr = ba;
    rd_addr   = {r1, r0};
    if (r) model_reset();
    q.push_back(expect_now());
  endtask

  task automatic idle(input logic [A-1:0] r0, input logic [A-1:0] r1);
    cyc(0, 0, 0, '0, '0, 0, '0, r0, r1);
  endtask

  function automatic logic [A-1:0] pick();
    if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, D - 1));
    return A'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
  endtask

  // Monitor: compare presented outputs against queued expectations.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a_ready", 32'(rdy_a), 32'(e.rdy[0]));
      chk("a_rd0", rdd_a[W-1:0], e.d[0][0]);
      chk("a_rd1", rdd_a[2*W-1:W], e.d[0][1]);
      chk("a_busy", 32'(rbz_a), 32'(e.b[0]));
      chk("b_ready", 32'(rdy_b), 32'(e.rdy[1]));
      chk("b_rd0", rdd_b[W-1:0], e.d[1][0]);
      chk("b_rd1", rdd_b[2*W-1:W], e.d[1][1]);
      chk("b_busy", 32'(rbz_b), 32'(e.b[1]));
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < D; j++) mm[i][j] = '0;
    repeat (2) @(posedge clk);

    // Garbage during the post-reset sweep.
    for (int i = 0; i < 40; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1, pick(), $urandom, 1, pick(),
          pick(), pick());

    // Every register reads zero after the sweep.
    for (int i = 0; i < D; i++) idle(A'(i), A'(D - 1 - i));

    // Write with same-cycle read, then read again.
    cyc(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, '0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Zero-register write.
    cyc(0, 0, 1, 5'd0, 32'h0000_1234, 0, '0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Scoreboard set / set-with-clear / clear.
    cyc(0, 0, 0, '0, '0, 1, 5'd7, 5'd0, 5'd7);
    idle(5'd0, 5'd7);
    cyc(0, 0, 1, 5'd7, 32'h7777_0001, 1, 5'd7, 5'd0, 5'd7);
    idle(5'd0, 5'd7);
    cyc(0, 0, 1, 5'd7, 32'h7777_0002, 0, '0, 5'd0, 5'd7);
    idle(5'd7, 5'd7);

    // Sequenced clear with busy and data present.
    cyc(0, 0, 1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    cyc(0, 1, 1, 5'd3, 32'h3333_3333, 1, 5'd3, 5'd3, 5'd9);
    for (int i = 0; i < 36; i++) idle(5'd3, 5'd9);

    // Reset part way through a sweep.
    cyc(0, 1, 0, '0, '0, 0, '0, 5'd1, 5'd2);
    for (int i = 0; i < 9; i++) idle(5'd1, 5'd2);
    cyc(1, 0, 0, '0, '0, 0, '0, 5'd1, 5'd2);
    for (int i = 0; i < 36; i++) idle(5'd1, 5'd2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0, 499) == 0),
          1'($urandom_range(0, 149) == 0),
          1'($urandom_range(0, 1)), pick(), $urandom,
          1'($urandom_range(0, 2) == 0), pick(), pick(), pick());

    idle(5'd0, 5'd1);
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
